// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate types.
// Imported by vga_axis_cnt and vga_timing_gen.
package vga_timing_pkg;

  localparam int VGA_CW = 10;
  localparam int VGA_MAX_TOTAL = 1 << VGA_CW;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [VGA_CW-1:0] coord_t;
  // One bit wider so totals up to 1024 are representable.
  typedef logic [VGA_CW:0]   span_t;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping counter plus next-state sync/active decode.
// Ports: clk, rst (sync, active-high), inc, total, sync_start,
// sync_end, active_len -> cnt, wrap, sync_n (next), active (next).
module vga_axis_cnt
  import vga_timing_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   inc,
  input  span_t  total,
  input  span_t  sync_start,
  input  span_t  sync_end,
  input  span_t  active_len,
  output coord_t cnt,
  output logic   wrap,
  output logic   sync_n,
  output logic   active
);

  coord_t cnt_q, cnt_d;
  span_t  cur_e, nxt_e, last;

  assign last  = total - span_t'(1);
  assign cur_e = {1'b0, cnt_q};
  assign wrap  = inc && (cur_e == last);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap)
      cnt_d = '0;
    else if (inc)
      cnt_d = cnt_q + coord_t'(1);
  end

  // Decode from the next count so the top can register it alongside.
  assign nxt_e  = {1'b0, cnt_d};
  assign sync_n = ~((nxt_e >= sync_start) && (nxt_e < sync_end));
  assign active = nxt_e < active_len;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: x/y, blank, sync, line/frame pulses.
// Ports: clk, rst -> x, y, active_pixels, hsync, vsync, line_start,
// frame_start, frame_cnt. Macro VGA_PIX_DIV2_EN: pixel tick = clk/2.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic              clk,
  input  logic              rst,
  output logic [VGA_CW-1:0] x,
  output logic [VGA_CW-1:0] y,
  output logic              active_pixels,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start,
  output logic [7:0]        frame_cnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOT > VGA_MAX_TOTAL) begin : g_h_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOT > VGA_MAX_TOTAL) begin : g_v_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  localparam span_t H_TOT_S = span_t'(H_TOT);
  localparam span_t H_SS    = span_t'(H_ACTIVE + H_FP);
  localparam span_t H_SE    = span_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam span_t H_ACT_S = span_t'(H_ACTIVE);
  localparam span_t V_TOT_S = span_t'(V_TOT);
  localparam span_t V_SS    = span_t'(V_ACTIVE + V_FP);
  localparam span_t V_SE    = span_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam span_t V_ACT_S = span_t'(V_ACTIVE);

  logic pix_en;

`ifdef VGA_PIX_DIV2_EN
  logic tog_q;

  // Counters move only on edges where the toggle reads 1.
  always_ff @(posedge clk) begin
    if (rst)
      tog_q <= 1'b0;
    else
      tog_q <= ~tog_q;
  end

  assign pix_en = tog_q;
`else
  assign pix_en = 1'b1;
`endif

  coord_t h_cnt, v_cnt;
  logic   h_wrap, h_sync_n, h_act;
  logic   v_wrap, v_sync_n, v_act;
  logic   v_inc;

  assign v_inc = pix_en & h_wrap;

  vga_axis_cnt u_h (
    .clk        (clk),
    .rst        (rst),
    .inc        (pix_en),
    .total      (H_TOT_S),
    .sync_start (H_SS),
    .sync_end   (H_SE),
    .active_len (H_ACT_S),
    .cnt        (h_cnt),
    .wrap       (h_wrap),
    .sync_n     (h_sync_n),
    .active     (h_act)
  );

  vga_axis_cnt u_v (
    .clk        (clk),
    .rst        (rst),
    .inc        (v_inc),
    .total      (V_TOT_S),
    .sync_start (V_SS),
    .sync_end   (V_SE),
    .active_len (V_ACT_S),
    .cnt        (v_cnt),
    .wrap       (v_wrap),
    .sync_n     (v_sync_n),
    .active     (v_act)
  );

  logic       act_q, hs_q, vs_q, ls_q, fs_q;
  logic [7:0] fc_q, fc_d;

  // v_wrap already implies h_wrap, so it marks the (0,0) wrap.
  assign fc_d = v_wrap ? fc_q + 8'd1 : fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b1;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= 8'd0;
    end else begin
      act_q <= h_act & v_act;
      hs_q  <= h_sync_n;
      vs_q  <= v_sync_n;
      ls_q  <= h_wrap;
      fs_q  <= v_wrap;
      fc_q  <= fc_d;
    end
  end

  assign x             = h_cnt;
  assign y             = v_cnt;
  assign active_pixels = act_q;
  assign hsync         = hs_q;
  assign vsync         = vs_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;
  assign frame_cnt     = fc_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Free-running VGA raster timing generator for the 640x480@60 display path. It drives the `x`, `y` and `active_pixels` bus that every pixel renderer samples, such as the win/lose/score overlays and the brick field. It also drives the `hsync`/`vsync` pins of the VGA DAC. Counters, sync and blank are registered and mutually aligned, so downstream combinational renderers see one coherent pixel coordinate per pixel slot.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `clk`  in  1  system clock. It is 25 MHz pixel clock, or 50 MHz when `VGA_PIX_DIV2_EN` is defined.
- `rst`  in  1  synchronous, active-high reset
- `x`  out  10  horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
- `y`  out  10  vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- `active_pixels`  out  1  high when `x < H_ACTIVE` and `y < V_ACTIVE`
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `line_start`  out  1  one-`clk` pulse when `x` becomes 0
- `frame_start`  out  1  one-`clk` pulse when (`x`,`y`) becomes (0,0)
- `frame_cnt`  out  8  frame counter, for blink/animation timing

## Operation
- Pixel tick `pix_en`:
  - Without the macro, `pix_en` is high every cycle.
  - With the macro, see Configuration.
- Horizontal counter `h` advances only on `pix_en`:
  - `h == H_TOTAL-1` → `h` becomes 0, else `h+1`.
- Vertical counter `v` advances on `pix_en` only when `h == H_TOTAL-1`:
  - `v == V_TOTAL-1` → `v` becomes 0, else `v+1`.
- Simultaneous wrap: at `h = 799`, `v = 524`, both counters go to 0 on the same edge.
- `x = h`, `y = v`. Both keep counting through blanking, and consumers must gate on `active_pixels`.
- `hsync` is low for `H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC`, i.e. h = 656..751.
- `vsync` is low for `V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC`, i.e. v = 490..491.
- All decoded outputs are registered from the next-state counter values, so they change on the same edge as `x`/`y`. There is no skew between coordinate and sync/blank.
- `frame_cnt` increments by 1 modulo 256 on every edge where `frame_start` is set; 255 wraps to 0.
- Parameter rule: H_TOTAL and V_TOTAL must each be ≤ 1024, to fit 10 bits. This is checked by elaboration-time assertion.

## Timing
- Reset values apply on the first `clk` edge with `rst` high, regardless of `pix_en`:
  - `x = 0`, `y = 0`, `active_pixels = 1`, `hsync = 1`, `vsync = 1`
  - `line_start = 0`, `frame_start = 0`, `frame_cnt = 0`
  - internal `pix_en` toggle = 0
- Reset mid-frame aborts the frame: the next edge returns all outputs to their reset values, and no `frame_start` is emitted for the aborted frame.
- First advance after release:
  - Without the macro, on the first edge with `rst` low, (`x`,`y`) goes from (0,0) to (1,0).
  - With the macro, on the second edge with `rst` low.
- Latency from counter change to sync/blank change is 0 cycles, because the outputs are co-registered.
- `line_start` and `frame_start` are set on the edge where the counters wrap and cleared on the following `clk` edge. They are exactly one `clk` wide, even when the macro is defined.
- Frame period = 800 × 525 pixel ticks = 420000 pixel ticks, i.e. 420000 `clk` without the macro and 840000 `clk` with it.

## Configuration
- `VGA_PIX_DIV2_EN`:
  - When defined, a 1-bit register toggles every `clk`, and counters advance only on edges where it reads 1. Each pixel coordinate is therefore held for 2 `clk`; this is used when `clk` is the 50 MHz board clock.
  - When undefined, the toggle register is absent and `pix_en` is tied to 1.

## Structure
- Package `vga_timing_pkg` holds:
  - default H/V porch/sync/active constants
  - derived `H_TOTAL`/`V_TOTAL`
  - the coordinate width constant `VGA_CW = 10`
- One sub-module, `vga_axis_cnt`, is instantiated twice, for horizontal and vertical. Its ports are:
  - `clk`, `rst`, `inc`, `total`, `sync_start`, `sync_end`, `active_len`
  - outputs: `cnt`, `wrap`, next-state `sync_n`, next-state `active`

## Test plan
- Reset: hold `rst` for 3 cycles, then release → `x = 0`, `y = 0`, `active_pixels = 1`, `hsync = 1`, `vsync = 1` during reset; `x = 1` one tick after release.
- Line timing, at `y = 0`:
  - `active_pixels` falls when `x` goes 639→640.
  - `hsync` falls at `x = 656` and rises at `x = 752`.
  - `line_start` pulses when `x` goes 799→0 and `y` goes 0→1.
- Frame timing:
  - `vsync` is low exactly for `y` = 490..491.
  - `frame_start` pulses once per 420000 ticks at the (799,524)→(0,0) wrap.
  - `frame_cnt` goes 0→1.
- Mid-frame reset: assert `rst` at `x = 300`, `y = 200` → the next edge gives (0,0), no `frame_start` pulse and `frame_cnt` unchanged at 0.
- Counter overflow: run 256 frames → `frame_cnt` goes 255→0 on the 256th `frame_start`.
- With `VGA_PIX_DIV2_EN` defined:
  - each `x` value is held for 2 `clk`
  - `frame_start` is 1 `clk` wide
  - frame period is 840000 `clk`
